// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, byte-write RAM (1-cycle registered read)
// between an instruction-fetch port (I, read only) and a load/store port (D).
// One requester is granted per cycle and the arbitration is combinational.
// The response appears one cycle after the grant. Out-of-range accesses are
// completed with err=1 and never touch the RAM.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN. When it is defined, simultaneous
// requests alternate between the ports. When it is undefined, D has fixed
// priority over I.
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 4096,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int BYTE_OFF   = $clog2(DATA_WIDTH/8)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_req,
  input  logic [31:0]               i_addr,
  output logic                      i_gnt,
  output logic                      i_rvalid,
  output logic [DATA_WIDTH-1:0]     i_rdata,
  output logic                      i_err,
  input  logic                      d_req,
  input  logic [DATA_WIDTH/8-1:0]   d_we,
  input  logic [31:0]               d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      d_err,
  output logic                      ram_en,
  output logic [DATA_WIDTH/8-1:0]   ram_we,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_din,
  input  logic [DATA_WIDTH-1:0]     ram_dout
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int HI = BYTE_OFF + ADDR_WIDTH;

  typedef enum logic [1:0] {RESP_NONE, RESP_I, RESP_D} owner_t;

  owner_t          resp_owner;
  logic            err_p1;
  logic            rd_ok_p1;
  logic            gnt_i_p0;
  logic            gnt_d_p0;
  logic            i_inr_p0;
  logic            d_inr_p0;
  logic            d_rd_p0;

  // An address is in range when no bit above the RAM word-address field is set.
  // The full 32 bits are checked, so addresses never wrap into the RAM.
  function automatic logic in_range(input logic [31:0] a);
    return (a >> HI) == 32'd0;
  endfunction

  assign i_inr_p0 = in_range(i_addr);
  assign d_inr_p0 = in_range(d_addr);
  assign d_rd_p0  = (d_we == '0);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;

  // Remember which port won the most recent grant so that contention alternates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (gnt_d_p0) begin
      last_d <= 1'b1;
    end else if (gnt_i_p0) begin
      last_d <= 1'b0;
    end
  end
`endif

  // Grant selection: a lone requester always wins; contention is resolved by policy.
  always_comb begin
    gnt_i_p0 = 1'b0;
    gnt_d_p0 = 1'b0;
    if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (last_d) begin
        gnt_i_p0 = 1'b1;
      end else begin
        gnt_d_p0 = 1'b1;
      end
`else
      gnt_d_p0 = 1'b1;
`endif
    end else begin
      gnt_i_p0 = i_req;
      gnt_d_p0 = d_req;
    end
  end

  assign i_gnt = gnt_i_p0;
  assign d_gnt = gnt_d_p0;

  // Drive the RAM from the winner. Out-of-range accesses keep the enable and strobes low.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt_d_p0) begin
      ram_addr = d_addr[BYTE_OFF +: ADDR_WIDTH];
      ram_din  = d_wdata;
      if (d_inr_p0) begin
        ram_en = 1'b1;
        ram_we = d_we;
      end
    end else if (gnt_i_p0) begin
      ram_addr = i_addr[BYTE_OFF +: ADDR_WIDTH];
      ram_en   = i_inr_p0;
    end
  end

  // Response owner FSM. It records who was granted on this edge, plus the
  // err and read-data qualifiers for that response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_owner <= RESP_NONE;
      err_p1     <= 1'b0;
      rd_ok_p1   <= 1'b0;
    end else if (gnt_d_p0) begin
      resp_owner <= RESP_D;
      err_p1     <= ~d_inr_p0;
      rd_ok_p1   <= d_inr_p0 & d_rd_p0;
    end else if (gnt_i_p0) begin
      resp_owner <= RESP_I;
      err_p1     <= ~i_inr_p0;
      rd_ok_p1   <= i_inr_p0;
    end else begin
      resp_owner <= RESP_NONE;
      err_p1     <= 1'b0;
      rd_ok_p1   <= 1'b0;
    end
  end

  // ---- response stage (p1): RAM read data is valid now ----
  assign i_rvalid = (resp_owner == RESP_I);
  assign d_rvalid = (resp_owner == RESP_D);
  assign i_err    = i_rvalid & err_p1;
  assign d_err    = d_rvalid & err_p1;
  assign i_rdata  = (i_rvalid && rd_ok_p1) ? ram_dout : '0;
  assign d_rdata  = (d_rvalid && rd_ok_p1) ? ram_dout : '0;

  // Byte count is implied by the strobe width.
  if (NB * 8 != DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end

endmodule
